// File: rtl/uart_rx_to_glitcher_fifo.sv
// uart_rx_to_glitcher_fifo: buffers UART rx bytes in a circular FIFO feeding a registered valid/ready stage; define RX_OVF_STICKY_EN for a sticky overflow flag
module uart_rx_to_glitcher_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_dv,
  input  logic [7:0]               rx_byte,
  input  logic                     glitcher_ready,
  input  logic                     ovf_clr,
  output logic                     glitcher_dv,
  output logic [7:0]               glitcher_byte,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [0:0]    state;
  logic          push, pop, drop;
  assign glitcher_dv = state == ST_FULL;
  assign drop = rx_dv && fifo_count == FULL_CNT;
  assign push = rx_dv && !drop;
  assign pop  = fifo_count != '0 && (state == ST_EMPTY || glitcher_ready);
  // storage is never reset; an entry is only read after it has been written
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= rx_byte;
  // pointers, occupancy, output register and the two-state output FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      state         <= ST_EMPTY;
      glitcher_byte <= '0;
    end else begin
      wr_ptr        <= push ? wr_ptr + PTR_ONE : wr_ptr;
      rd_ptr        <= pop ? rd_ptr + PTR_ONE : rd_ptr;
      fifo_count    <= (push && !pop) ? fifo_count + CNT_ONE :
                       (pop && !push) ? fifo_count - CNT_ONE : fifo_count;
      glitcher_byte <= pop ? mem[rd_ptr] : glitcher_byte;
      state         <= pop ? ST_FULL : glitcher_ready ? ST_EMPTY : state;
    end
  end
`ifdef RX_OVF_STICKY_EN
  // sticky drop flag; a drop on the same edge as ovf_clr keeps it set
  always_ff @(posedge clk)
    overflow <= rst ? 1'b0 : drop | (overflow & ~ovf_clr);
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  // one-cycle pulse per dropped byte
  always_ff @(posedge clk)
    overflow <= rst ? 1'b0 : drop;
`endif
endmodule

// File: tb/tb_uart_rx_to_glitcher_fifo.sv
// tb_uart_rx_to_glitcher_fifo: directed vector table plus a wrap-around stream for the rx FIFO
module tb_uart_rx_to_glitcher_fifo;
  localparam int DEPTH = 4;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = '0;
  logic       glitcher_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       glitcher_dv;
  logic [7:0] glitcher_byte;
  logic       overflow;
  logic [2:0] fifo_count;
  int n_vec = 0;
  int n_err = 0;
  typedef struct {
    logic       rst, dv;
    logic [7:0] b;
    logic       rdy, clr, e_dv;
    logic [7:0] e_b;
    logic       e_op, e_os;
    logic [2:0] e_cnt;
  } vec_t;
  vec_t v[$];
  uart_rx_to_glitcher_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .glitcher_ready(glitcher_ready), .ovf_clr(ovf_clr),
    .glitcher_dv(glitcher_dv), .glitcher_byte(glitcher_byte),
    .overflow(overflow), .fifo_count(fifo_count)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic e_ovf;
    int sent, got, cyc;
    logic pdv, prdy;
    logic [7:0] pb;
    // rst dv byte rdy clr | dv byte ovf_pulse ovf_sticky cnt
    v.push_back('{1,0,8'h00,0,0, 0,8'h00,0,0,0});
    v.push_back('{1,0,8'h00,0,0, 0,8'h00,0,0,0});
    v.push_back('{0,1,8'hA5,1,0, 0,8'h00,0,0,1});
    v.push_back('{0,0,8'h00,1,0, 1,8'hA5,0,0,0});
    v.push_back('{0,0,8'h00,1,0, 0,8'hA5,0,0,0});
    v.push_back('{0,1,8'h01,0,0, 0,8'hA5,0,0,1});
    v.push_back('{0,1,8'h02,0,0, 1,8'h01,0,0,1});
    v.push_back('{0,1,8'h03,0,0, 1,8'h01,0,0,2});
    v.push_back('{0,1,8'h04,0,0, 1,8'h01,0,0,3});
    v.push_back('{0,1,8'h05,0,0, 1,8'h01,0,0,4});
    v.push_back('{0,1,8'h06,0,0, 1,8'h01,1,1,4});
    v.push_back('{0,0,8'h00,0,0, 1,8'h01,0,1,4});
    v.push_back('{0,0,8'h00,0,1, 1,8'h01,0,0,4});
    v.push_back('{0,1,8'h07,1,0, 1,8'h02,1,1,3});
    v.push_back('{0,0,8'h00,1,0, 1,8'h03,0,1,2});
    v.push_back('{0,0,8'h00,1,1, 1,8'h04,0,0,1});
    v.push_back('{0,0,8'h00,1,0, 1,8'h05,0,0,0});
    v.push_back('{0,0,8'h00,1,0, 0,8'h05,0,0,0});
    v.push_back('{0,1,8'h10,0,0, 0,8'h05,0,0,1});
    v.push_back('{0,1,8'h11,0,0, 1,8'h10,0,0,1});
    v.push_back('{0,1,8'h12,0,0, 1,8'h10,0,0,2});
    v.push_back('{0,1,8'h13,0,0, 1,8'h10,0,0,3});
    v.push_back('{0,1,8'h14,0,0, 1,8'h10,0,0,4});
    v.push_back('{0,1,8'h15,0,1, 1,8'h10,1,1,4});
    v.push_back('{0,0,8'h00,1,0, 1,8'h11,0,1,3});
    v.push_back('{1,1,8'h16,0,0, 0,8'h00,0,0,0});
    v.push_back('{0,1,8'h3C,1,0, 0,8'h00,0,0,1});
    v.push_back('{0,0,8'h00,1,0, 1,8'h3C,0,0,0});
    v.push_back('{0,0,8'h00,1,0, 0,8'h3C,0,0,0});
    foreach (v[i]) begin
      rst = v[i].rst; rx_dv = v[i].dv; rx_byte = v[i].b;
      glitcher_ready = v[i].rdy; ovf_clr = v[i].clr;
      step();
`ifdef RX_OVF_STICKY_EN
      e_ovf = v[i].e_os;
`else
      e_ovf = v[i].e_op;
`endif
      n_vec++;
      if (glitcher_dv !== v[i].e_dv || glitcher_byte !== v[i].e_b ||
          overflow !== e_ovf || fifo_count !== v[i].e_cnt) begin
        n_err++;
        $display("FAIL vec%0d: got dv=%b byte=%h ovf=%b cnt=%0d, want dv=%b byte=%h ovf=%b cnt=%0d",
                 i, glitcher_dv, glitcher_byte, overflow, fifo_count,
                 v[i].e_dv, v[i].e_b, e_ovf, v[i].e_cnt);
      end
    end
    sent = 0; got = 0; cyc = 0;
    while (got < 3*DEPTH && cyc < 1000) begin
      rx_dv = sent < 3*DEPTH && fifo_count < DEPTH;
      rx_byte = 8'(sent);
      glitcher_ready = 1'($urandom_range(0, 1));
      ovf_clr = 1'b0;
      pdv = glitcher_dv; pb = glitcher_byte; prdy = glitcher_ready;
      if (rx_dv) sent++;
      step();
      cyc++;
      if (pdv && prdy) begin
        n_vec++;
        if (pb !== 8'(got)) begin
          n_err++;
          $display("FAIL wrap_order: got %h want %h", pb, 8'(got));
        end
        got++;
      end
      n_vec++;
      if (overflow !== 1'b0) begin
        n_err++;
        $display("FAIL wrap_ovf: got %b want 0 at cycle %0d", overflow, cyc);
      end
    end
    n_vec++;
    if (got != 3*DEPTH) begin
      n_err++;
      $display("FAIL wrap_timeout: got %0d bytes want %0d", got, 3*DEPTH);
    end
    rx_dv = 1'b0; glitcher_ready = 1'b1;
    step(); step();
    n_vec++;
    if (glitcher_dv !== 1'b0 || fifo_count !== 3'd0) begin
      n_err++;
      $display("FAIL wrap_drain: got dv=%b cnt=%0d want dv=0 cnt=0", glitcher_dv, fifo_count);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_to_glitcher_fifo.md
# uart_rx_to_glitcher_fifo

Receive-side companion of the glitcher-to-UART transmit path. Accepts single-cycle byte strobes from the UART receiver, buffers them in a small circular FIFO, and presents them to the glitcher control logic through a registered valid/ready output stage. It absorbs host bursts while the glitcher is busy and flags every byte it is forced to drop.

## Interface
Parameters:
- DEPTH, 4: FIFO storage entries; power of two, 2..256. Total buffering is DEPTH plus one output-register byte.

Ports:
- clk  in  1  single system clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- rx_dv  in  1  one-cycle strobe from the UART receiver; rx_byte valid
- rx_byte  in  8  received byte
- glitcher_ready  in  1  glitcher accepts glitcher_byte this cycle
- ovf_clr  in  1  clears sticky overflow; ignored unless RX_OVF_STICKY_EN is defined
- glitcher_dv  out  1  glitcher_byte valid; held until accepted
- glitcher_byte  out  8  byte presented to the glitcher
- overflow  out  1  byte-dropped indication (pulse or sticky, see Configuration)
- fifo_count  out  $clog2(DEPTH)+1  bytes currently stored in the FIFO, excluding the output register

## Operation
- Storage: array of DEPTH x 8; wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. count is $clog2(DEPTH)+1 bits, range 0..DEPTH.
- Write: on an edge with rx_dv=1 and count<DEPTH, store rx_byte at wr_ptr, then wr_ptr+1.
- Drop: on an edge with rx_dv=1 and count==DEPTH, discard the byte, leave pointers unchanged, and raise overflow. Fullness uses the pre-edge count, so a simultaneous pop does not rescue the write.
- Output FSM, two states:
  - EMPTY (glitcher_dv=0): if count>0, load fifo[rd_ptr] into glitcher_byte, advance rd_ptr, go to FULL.
  - FULL (glitcher_dv=1): hold glitcher_byte stable. If glitcher_ready=1 and count>0, load the next byte and stay in FULL, giving one byte per cycle. If glitcher_ready=1 and count==0, go to EMPTY. If glitcher_ready=0, hold.
- Count update: +1 on write only, -1 on pop only, unchanged on both or neither. No underflow is possible, because a pop requires count>0.
- rx_dv has no flow control; the receiver is never stalled.
- Reset, at any time including mid-burst: state=EMPTY, glitcher_dv=0, glitcher_byte=0, overflow=0, fifo_count=0, both pointers 0. Storage contents are not reset and are never read while stale.

## Timing
- Latency: rx_dv sampled at edge E into an empty block -> glitcher_dv=1 with that byte after edge E+1.
- Handshake: a transfer occurs on an edge where glitcher_dv=1 and glitcher_ready=1. glitcher_dv never deasserts without a transfer, except on rst.
- glitcher_ready is a don't-care while glitcher_dv=0.
- Throughput: sustained one byte per cycle in and out.
- fifo_count and overflow are registered and reflect the state after the edge.

## Configuration
- RX_OVF_STICKY_EN defined:
  - overflow sets on the first drop and stays 1 until rst or ovf_clr=1.
  - If ovf_clr and a drop occur on the same edge, the set wins and overflow stays 1.
- RX_OVF_STICKY_EN undefined:
  - overflow is a one-cycle pulse on the edge of each dropped byte.
  - ovf_clr is unused.

## Test plan
- Single byte: rx_dv with 0xA5 at edge E, glitcher_ready=1 -> glitcher_dv=1 with 0xA5 after E+1; glitcher_dv=0 after E+2; fifo_count returns to 0.
- Backpressure and ordering (DEPTH=4): glitcher_ready=0, send 0x01..0x05 on consecutive cycles -> glitcher_byte=0x01 and fifo_count=4, no overflow. Release ready -> 0x01..0x05 delivered on consecutive cycles.
- Overflow: glitcher_ready=0, send 6 bytes -> 6th byte dropped, overflow asserted, remaining bytes delivered in order.
  - Sticky build: overflow stays 1 until an ovf_clr pulse.
  - Non-sticky build: overflow is a 1-cycle pulse.
- Wrap-around: stream 3xDEPTH bytes (0x00 upward) with glitcher_ready toggling randomly -> every byte received exactly once, in order, and pointers wrap without loss.
- Simultaneous push and pop while full: count==DEPTH, glitcher_ready=1 and rx_dv=1 on the same edge -> incoming byte dropped, overflow raised, fifo_count drops to DEPTH-1.
- Reset mid-burst: assert rst with 3 bytes buffered -> next edge gives glitcher_dv=0, fifo_count=0, overflow=0. A new byte 0x3C after rst deasserts is the first byte delivered.
